// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial subtraction controller: computes a - b - bin over WIDTH bits,
// one full-subtractor step per clock, LSB first, with the running borrow
// held in a flop between steps.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous reset, active-high, overrides everything
//   start  : request, sampled only while busy=0
//   a, b   : minuend / subtrahend, captured on the accepting edge
//   bin    : borrow-in, captured on the accepting edge
//   busy   : operation in progress (WIDTH cycles per operation)
//   done   : one-cycle pulse, diff/bout were just updated
//   diff   : registered (a - b - bin) mod 2^WIDTH
//   bout   : registered final borrow, 1 when a < b + bin (unsigned)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results hold; start here loads the operands
// RUN   | one bit step per edge; the cnt==WIDTH-1 step publishes results

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [4:0]       cnt;
    logic             borrow;
    logic             bit_d;
    logic             borrow_nxt;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] d_shift;

    // full-subtractor cell on the current LSBs
    assign bit_d      = a_sh[0] ^ b_sh[0] ^ borrow;
    assign borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // d_sh only needs the upper WIDTH-1 result bits; the last step's cell
    // output supplies the MSB directly, so the shifted-out bit is never stored.
    generate
        if (WIDTH == 1) begin : g_w1
            assign d_shift = bit_d;
        end else begin : g_wn
            logic [WIDTH-1:1] d_sh;

            assign d_shift = {bit_d, d_sh};

            always_ff @(posedge clk) begin
                if (rst || load) begin
                    d_sh <= '0;
                end else if (step) begin
                    d_sh <= d_shift[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_sh   <= a;
                b_sh   <= b;
                borrow <= bin;
                cnt    <= '0;
            end else if (step) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                borrow <= borrow_nxt;
                if (last) begin
                    diff <= d_shift;
                    bout <= borrow_nxt;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Testbench for serial_sub_ctrl: three instances (WIDTH 8, 4, 1) each with a
// scoreboard queue of expected results computed by plain integer arithmetic.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int W = (gi == 0) ? 8 : ((gi == 1) ? 4 : 1);

        logic         rst   = 1'b1;
        logic         start = 1'b0;
        logic         bin   = 1'b0;
        logic [W-1:0] a     = '0;
        logic [W-1:0] b     = '0;
        logic         busy;
        logic         done;
        logic         bout;
        logic [W-1:0] diff;
        bit           fin = 1'b0;

        serial_sub_ctrl #(.WIDTH(W)) dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .a    (a),
            .b    (b),
            .bin  (bin),
            .busy (busy),
            .done (done),
            .diff (diff),
            .bout (bout)
        );

        int           q_due[$];
        logic [W:0]   q_res[$];
        int           cyc        = 0;
        int           busy_until = 0;
        int           due;
        logic [W:0]   res;
        logic [W-1:0] m_diff     = '0;
        logic         m_bout     = 1'b0;

        function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic z);
            longint     full;
            logic [W:0] r;
            full       = longint'(x) - longint'(y) - longint'(z);
            r[W-1:0]   = full[W-1:0];
            r[W]       = (full < 0);
            return r;
        endfunction

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: cyc counts edges seen so far.  An op accepted at edge k
        // is expected to pulse done after edge k+W and keep busy for edges k..k+W-1.
        always @(negedge clk) begin
            if (cyc > 0) begin
                chk($sformatf("w%0d_busy@%0d", W, cyc), busy, cyc < busy_until);
                chk($sformatf("w%0d_done_busy_excl@%0d", W, cyc), done & busy, 1'b0);
                if (done) begin
                    if (q_due.size() == 0) begin
                        chk($sformatf("w%0d_unexpected_done@%0d", W, cyc), done, 1'b0);
                    end else begin
                        due = q_due.pop_front();
                        res = q_res.pop_front();
                        chk($sformatf("w%0d_latency", W), cyc, due);
                        m_diff = res[W-1:0];
                        m_bout = res[W];
                    end
                end else if (q_due.size() > 0 && cyc >= q_due[0]) begin
                    chk($sformatf("w%0d_missing_done@%0d", W, cyc), done, 1'b1);
                    due    = q_due.pop_front();
                    res    = q_res.pop_front();
                    m_diff = res[W-1:0];
                    m_bout = res[W];
                end
                chk($sformatf("w%0d_diff@%0d", W, cyc), diff, m_diff);
                chk($sformatf("w%0d_bout@%0d", W, cyc), bout, m_bout);
            end
            // predict the effect of the upcoming edge
            if (rst) begin
                q_due.delete();
                q_res.delete();
                busy_until = 0;
                m_diff     = '0;
                m_bout     = 1'b0;
            end else if (start && cyc >= busy_until) begin
                q_due.push_back(cyc + 1 + W);
                q_res.push_back(ref_sub(a, b, bin));
                busy_until = cyc + 1 + W;
            end
        end

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        // Present one request, scramble inputs after acceptance, and return
        // during the done cycle (so gap=0 gives back-to-back operations).
        task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic z,
                             input int gap);
            a     = x;
            b     = y;
            bin   = z;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            idle(W);
            idle(gap);
        endtask

        if (W == 8) begin : g_dir
            initial begin
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                idle(2);
                issue(8'h05, 8'h03, 1'b0, 0);
                issue(8'h03, 8'h05, 1'b0, 1);
                issue(8'h00, 8'h00, 1'b1, 0);
                issue(8'h80, 8'h7F, 1'b1, 2);
                // start while busy is ignored, start during done is accepted
                a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
                idle(1);
                start = 1'b0;
                idle(2);
                a = 8'hFF; b = 8'hFF; start = 1'b1;
                idle(1);
                start = 1'b0;
                idle(5);
                a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
                idle(2);
                start = 1'b0;
                idle(W + 2);
                // reset in the middle of a run
                a = 8'hC3; b = 8'h21; bin = 1'b1; start = 1'b1;
                idle(1);
                start = 1'b0;
                idle(3);
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                idle(W + 3);
                issue(8'h5A, 8'h3C, 1'b0, 1);
                repeat (150) issue(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
                idle(W + 3);
                fin = 1'b1;
            end
        end else begin : g_sweep
            initial begin
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                idle(2);
                for (int x = 0; x < (1 << W); x++) begin
                    for (int y = 0; y < (1 << W); y++) begin
                        for (int z = 0; z < 2; z++) begin
                            issue(W'(x), W'(y), 1'(z), $urandom_range(0, 3));
                        end
                    end
                end
                idle(W + 3);
                fin = 1'b1;
            end
        end
    end

    initial begin
        int k;
        k = 0;
        while (!(g[0].fin && g[1].fin && g[2].fin) && k < 60000) begin
            @(posedge clk);
            k++;
        end
        chk("all_streams_finished", {g[0].fin, g[1].fin, g[2].fin}, 3'b111);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
